// File: rtl/mesh_traffic_gen.sv
// Synthetic head/body/tail packet injector feeding a mesh router local input port.
// Optional build macro MESH_TG_SELF_FILTER_EN remaps self-addressed destinations.
module mesh_traffic_gen #(
  parameter int          WIDTH   = 15,
  parameter int          SRC_X   = 0,
  parameter int          SRC_Y   = 0,
  parameter int          MESH_X  = 4,
  parameter int          MESH_Y  = 4,
  parameter int          PKT_LEN = 4,
  parameter int          GAP     = 2,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      pkt_count,
  output logic             busy
);

  // Handshake: a flit transfers on a rising edge where out_valid && out_ready;
  // once raised, out_valid and out_data hold until that edge, never retracted.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]       state, state_n;
  logic [15:0]      lfsr, lfsr_n;
  logic [4:0]       seq, seq_n;
  logic [7:0]       idx, idx_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic             valid_n, busy_n;
  logic [WIDTH-1:0] data_n;
  logic [15:0]      count_n;
  logic             accept, start_head, go_idle;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [WIDTH-1:0] head_flit(input logic [3:0] l, input logic [4:0] s);
    logic [1:0]       dx;
    logic [1:0]       dy;
    logic [WIDTH-1:0] f;
    dx = 2'(int'(l[1:0]) % MESH_X);
    dy = 2'(int'(l[3:2]) % MESH_Y);
`ifdef MESH_TG_SELF_FILTER_EN
    if (dx == 2'(SRC_X) && dy == 2'(SRC_Y)) begin
      if (MESH_X > 1) dx = 2'((int'(dx) + 1) % MESH_X);
      else if (MESH_Y > 1) dy = 2'((int'(dy) + 1) % MESH_Y);
    end
`endif
    f = '0;
    f[14:0] = {2'b01, dx, dy, 2'(SRC_X), 2'(SRC_Y), s};
    return f;
  endfunction

  function automatic logic [WIDTH-1:0] body_flit(input logic [4:0] s, input logic [7:0] i);
    logic [WIDTH-1:0] f;
    f = '0;
    f[14:0] = {(i == LAST_IDX) ? 2'b10 : 2'b00, s, i};
    return f;
  endfunction

  assign accept = out_valid && out_ready;

  always_comb begin
    state_n    = state;
    lfsr_n     = lfsr;
    seq_n      = seq;
    idx_n      = idx;
    gap_n      = gap_cnt;
    valid_n    = out_valid;
    data_n     = out_data;
    count_n    = pkt_count;
    busy_n     = busy;
    start_head = 1'b0;
    go_idle    = 1'b0;
    case (state)
      S_IDLE: if (en) start_head = 1'b1;
      S_HEAD: if (accept) begin
        lfsr_n  = lfsr_step(lfsr);
        idx_n   = 8'd1;
        state_n = S_BODY;
        data_n  = body_flit(seq, 8'd1);
      end
      S_BODY: if (accept) begin
        if (idx == LAST_IDX) begin
          seq_n = seq + 5'd1;
          idx_n = 8'd0;
          if (pkt_count != 16'hFFFF) count_n = pkt_count + 16'd1;
          if (GAP == 0) begin
            if (en) start_head = 1'b1;
            else    go_idle    = 1'b1;
          end else begin
            state_n = S_GAP;
            gap_n   = GAP_LOAD;
            valid_n = 1'b0;
            data_n  = '0;
          end
        end else begin
          idx_n  = idx + 8'd1;
          data_n = body_flit(seq, idx + 8'd1);
        end
      end
      default: begin
        if (gap_cnt == '0) begin
          if (en) start_head = 1'b1;
          else    go_idle    = 1'b1;
        end else begin
          gap_n = gap_cnt - 1'b1;
        end
      end
    endcase
    // Head content uses the post-update seq so back-to-back packets number correctly.
    if (start_head) begin
      state_n = S_HEAD;
      valid_n = 1'b1;
      busy_n  = 1'b1;
      data_n  = head_flit(lfsr_n[3:0], seq_n);
    end
    if (go_idle) begin
      state_n = S_IDLE;
      valid_n = 1'b0;
      busy_n  = 1'b0;
      data_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      seq       <= 5'd0;
      idx       <= 8'd0;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      pkt_count <= 16'd0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      seq       <= seq_n;
      idx       <= idx_n;
      gap_cnt   <= gap_n;
      out_valid <= valid_n;
      out_data  <= data_n;
      pkt_count <= count_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_mesh_traffic_gen.sv
// Bench for mesh_traffic_gen: packet-level reference model with a flit queue,
// directed phases plus randomized en/out_ready traffic.
module tb_mesh_traffic_gen;

  localparam int          PKT_LEN = 4;
  localparam int          GAP     = 2;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n, en, out_ready, en2, ready2;
  logic        out_valid, busy, out_valid2, busy2;
  logic [14:0] out_data, out_data2;
  logic [15:0] pkt_count, pkt_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mesh_traffic_gen #(.WIDTH(15), .SRC_X(0), .SRC_Y(0), .MESH_X(4), .MESH_Y(4),
                     .PKT_LEN(PKT_LEN), .GAP(GAP), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .pkt_count(pkt_count), .busy(busy));

  mesh_traffic_gen #(.WIDTH(15), .SRC_X(1), .SRC_Y(0), .MESH_X(4), .MESH_Y(4),
                     .PKT_LEN(2), .GAP(0), .SEED(SEED)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .out_ready(ready2),
    .out_valid(out_valid2), .out_data(out_data2), .pkt_count(pkt_count2), .busy(busy2));

  // Reference model state
  logic [14:0] exp_q[$];
  logic [15:0] m_lfsr;
  int          m_seq, m_count, low_cnt;
  logic        prev_valid, prev_ready, gap_armed, check_gap;
  logic [14:0] prev_data;

  function automatic logic [15:0] lfsr_next(logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return (l << 1) | {15'd0, fb};
  endfunction

  function automatic logic [14:0] exp_head(logic [15:0] l, int s, int sx, int sy, int mx, int my);
    int dx, dy;
    dx = int'(l[1:0]) % mx;
    dy = int'(l[3:2]) % my;
`ifdef MESH_TG_SELF_FILTER_EN
    if (dx == sx && dy == sy) begin
      if (mx > 1) dx = (dx + 1) % mx;
      else if (my > 1) dy = (dy + 1) % my;
    end
`endif
    return {2'b01, 2'(dx), 2'(dy), 2'(sx), 2'(sy), 5'(s)};
  endfunction

  function automatic logic [14:0] exp_body(int s, int i, int plen);
    return {(i == plen - 1) ? 2'b10 : 2'b00, 5'(s), 8'(i)};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_lfsr = SEED; m_seq = 0; m_count = 0; low_cnt = 0;
    prev_valid = 0; prev_ready = 0; prev_data = '0; gap_armed = 0;
  endtask

  // Runs at the negedge; predicts what the coming posedge accepts.
  task automatic monitor();
    check("pkt_count", pkt_count, 32'(m_count));
    if (prev_valid && !prev_ready) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
    end
    if (!out_valid) begin
      low_cnt++;
    end else if (exp_q.size() == 0) begin
      if (!prev_valid && gap_armed && check_gap) check("gap_len", low_cnt, GAP);
      gap_armed = 0;
      check("head", out_data, exp_head(m_lfsr, m_seq, 0, 0, 4, 4));
      if (out_ready) begin
        for (int i = 1; i < PKT_LEN; i++) exp_q.push_back(exp_body(m_seq, i, PKT_LEN));
        m_lfsr = lfsr_next(m_lfsr);
      end
    end else begin
      check("flit", out_data, exp_q[0]);
      if (out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_seq = (m_seq + 1) % 32;
          if (m_count < 65535) m_count++;
          low_cnt = 0;
          gap_armed = 1;
        end
      end
    end
    prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] l2;
    logic [14:0] hold;
    int n, c0;
    rst_n = 0; en = 0; out_ready = 0; en2 = 0; ready2 = 0; check_gap = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_count", pkt_count, 0);
    check("rst_busy", busy, 0);

    // First packet with en and out_ready held high
    rst_n = 1; en = 1; out_ready = 1;
    @(posedge clk); #1;
    check("first_head_valid", out_valid, 1);
    check("first_head", out_data, 15'h2800);
    check("first_busy", busy, 1);
    check_gap = 1;
    repeat (PKT_LEN) tick();
    check("count_after_first", pkt_count, 1);
    check("gap_valid_low", out_valid, 0);
    check("gap_busy", busy, 1);
    repeat (GAP) tick();
    check("second_head_valid", out_valid, 1);
    check("second_head", out_data, exp_head(lfsr_next(SEED), 1, 0, 0, 4, 4));
    repeat (20) tick();
    check_gap = 0;

    // Randomized en / out_ready
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 9) != 0);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Stall on a head for five cycles
    en = 1; out_ready = 1; n = 0;
    while (out_valid && n < 50) begin tick(); n++; end
    check("wait_idle_gap", 32'(n < 50), 1);
    out_ready = 0; n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check("wait_head", 32'(n < 50 && exp_q.size() == 0), 1);
    hold = out_data; c0 = m_count;
    repeat (5) tick();
    check("stall_data", out_data, hold);
    check("stall_valid", out_valid, 1);
    out_ready = 1;
    repeat (PKT_LEN) tick();
    check("stall_complete", pkt_count, 32'(c0 + 1));
    repeat (GAP + 1) tick();

    // Drop en during a body flit
    n = 0;
    while (!(out_valid && exp_q.size() >= 2) && n < 50) begin tick(); n++; end
    check("wait_body", 32'(n < 50), 1);
    c0 = m_count;
    en = 0; n = 0;
    while (exp_q.size() > 0 && n < 20) begin tick(); n++; end
    check("drain_done", 32'(n < 20), 1);
    check("drop_count", pkt_count, 32'(c0 + 1));
    check("drop_gap_busy", busy, 1);
    repeat (GAP + 2) tick();
    check("drop_idle_busy", busy, 0);
    check("drop_idle_valid", out_valid, 0);
    repeat (5) tick();
    check("drop_still_idle", out_valid, 0);

    // Asynchronous reset mid-body
    en = 1; n = 0;
    while (!(out_valid && exp_q.size() >= 2) && n < 50) begin tick(); n++; end
    check("wait_body2", 32'(n < 50), 1);
    #2 rst_n = 0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_data", out_data, 0);
    check("async_count", pkt_count, 0);
    check("async_busy", busy, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1; en = 1; out_ready = 1;
    @(posedge clk); #1;
    check("post_rst_head", out_data, 15'h2800);
    repeat (30) tick();

    // PKT_LEN = 2, GAP = 0 instance, source (1,0)
    en = 0;
    en2 = 1; ready2 = 1;
    @(posedge clk); #1;
`ifdef MESH_TG_SELF_FILTER_EN
    check("filter_head", out_data2, 15'h3080);
`else
    check("filter_head", out_data2, 15'h2880);
`endif
    l2 = SEED;
    for (int p = 0; p < 5; p++) begin
      check("b2b_head_valid", out_valid2, 1);
      check("b2b_head", out_data2, exp_head(l2, p, 1, 0, 4, 4));
      @(posedge clk); #1;
      l2 = lfsr_next(l2);
      check("b2b_tail_valid", out_valid2, 1);
      check("b2b_tail", out_data2, exp_body(p, 1, 2));
      @(posedge clk); #1;
      check("b2b_count", pkt_count2, 32'(p + 1));
      check("b2b_busy", busy2, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
